binary_to_gray_counter: RTL and testbench
=========================================

Name: binary_to_gray_counter

Overview:
Registered binary counter that publishes its value in both binary and Gray code. It is the encode-side counterpart of the Gray-to-binary decoder. The block sits in the write or read domain of a clock-crossing FIFO and drives a pointer that another domain resynchronizes and decodes. The Gray output is driven directly from flops, so only one bit changes per increment and the output is glitch-free for CDC capture.

Parameters:
WIDTH, 5, counter width in bits; the count range is 0 .. 2^WIDTH-1 and wraps modulo 2^WIDTH.

Ports:
clock  input  1  single clock; all state updates on the rising edge.
aclr_n  input  1  asynchronous, active-low reset.
sclr  input  1  synchronous clear to zero; highest synchronous priority.
load  input  1  synchronous load of load_value.
load_value  input  WIDTH  binary value to load.
inc  input  1  increment by one.
bin_out  output  WIDTH  registered binary count.
gray_out  output  WIDTH  registered Gray encoding of bin_out; bit i = bin[i] ^ bin[i+1], MSB = bin MSB.
wrap  output  1  registered one-cycle pulse; the counter wrapped from all-ones to zero through inc.

Behaviour:
- Reset (aclr_n low, asynchronous assert): bin_out = 0, gray_out = 0, wrap = 0. Release is synchronous to clock at the integration level; the block adds no synchronizer.
- Next-state priority, evaluated each rising edge: sclr > load > inc > hold.
  - sclr: next = 0.
  - load: next = load_value.
  - inc: next = bin_out + 1, modulo 2^WIDTH; the carry is discarded.
  - otherwise: hold.
- gray_out is registered from the Gray encoding of the next binary value, computed in the same cycle. It is never derived combinationally from bin_out after the flop. bin_out and gray_out therefore always correspond in the same cycle, and latency is 1 clock from the control input to both outputs.
- wrap = 1 for exactly the cycle after an edge where inc was taken, bin_out was all-ones, and neither sclr nor load was asserted. Otherwise wrap = 0.
  - A load or sclr to zero from all-ones does not pulse wrap.
- Gray property: on every inc-taken edge, gray_out changes in exactly one bit, including the wrap from all-ones to zero.
  - load and sclr may change several bits; integrators must only apply them while the far domain is quiescent.
- Simultaneous events:
  - sclr with load and/or inc: clear wins, wrap = 0.
  - load with inc: load wins, no increment applied.
- Reset mid-operation: aclr_n low forces all outputs to zero immediately, regardless of clock. The first edge after release follows the normal priority rules.
- WIDTH = 1 is legal: gray_out equals bin_out.

Decomposition:
- Shared package gray_code_pkg holds:
  - function bin2gray(logic [N-1:0]), parameterized via a width parameter on the package function or a parameterized class.
  - function gray2bin for bench checking.
  - constant GRAY_DEFAULT_WIDTH = 5.
- One sub-module is natural: bin2gray_comb, purely combinational, WIDTH-parameterized. It encodes the next-state binary value feeding the gray register. It is reused by future FIFO pointer blocks.

Test Plan (WIDTH=5):
- Reset: hold aclr_n low with inc=1 -> bin_out=0, gray_out=0, wrap=0. Assert aclr_n low mid-count at bin 13 -> outputs go to 0 without waiting for a clock edge.
- Increment sweep: inc=1 for 64 cycles from 0.
  - Spot checks: bin 5 -> gray 7; bin 10 -> gray 15; bin 31 -> gray 16.
  - Every step changes exactly one gray bit, and gray2bin(gray_out) == bin_out on every cycle.
- Wrap: from bin 31 with inc=1 -> next cycle bin 0, gray 0, wrap=1 for one cycle. During the 64-cycle sweep wrap pulses exactly twice.
- Load: load=1, load_value=19, inc=1 -> next cycle bin 19, gray 26, no increment applied, wrap=0.
- Priority: sclr=1, load=1, load_value=7, inc=1 at bin 31 -> next cycle bin 0, gray 0, wrap=0.
- Hold: inc=0, sclr=0, load=0 for 10 cycles at bin 22 -> bin stays 22, gray stays 29, wrap stays 0.

Source files
------------

// File: rtl/gray_code_pkg.sv
// ---------------------------------------------------------------------------
// gray_code_pkg
//
// Shared definitions for binary/Gray pointer logic used by clock-crossing
// FIFO blocks.
//
// Contents:
//   GRAY_DEFAULT_WIDTH : default counter/pointer width
//   GRAY_MAX_WIDTH     : widest value the helper functions accept
//   next_sel_e         : which source feeds the next counter value
//   bin2gray()         : binary -> Gray for values up to GRAY_MAX_WIDTH bits
//   gray2bin()         : Gray -> binary for values up to GRAY_MAX_WIDTH bits
//
// Both helper functions work on zero-extended values. The bits above a
// narrower operand's width stay zero, so a caller can cast its result back
// down to its own width without any loss.
// ---------------------------------------------------------------------------
package gray_code_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 5;
    localparam int GRAY_MAX_WIDTH     = 32;

    // Source of the next counter value, listed from lowest to highest priority.
    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_INC   = 2'd1,
        SEL_LOAD  = 2'd2,
        SEL_CLEAR = 2'd3
    } next_sel_e;

    // Each Gray bit is the XOR of a binary bit and the binary bit above it.
    // The top bit is XORed with a zero-extended bit, so it passes through
    // unchanged.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

    // Decoding runs from the MSB downward. Each binary bit is the XOR of the
    // Gray bit at the same position and the binary bit already decoded above it.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] gray
    );
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin = '0;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin2gray_comb.sv
// ---------------------------------------------------------------------------
// bin2gray_comb
//
// Purely combinational binary-to-Gray encoder. It is meant to sit in front of
// a Gray register, so the register captures an already-encoded value.
//
// Parameters:
//   WIDTH   : operand width in bits (1 or more)
//
// Ports:
//   i_bin   : input  [WIDTH-1:0]  binary value
//   o_gray  : output [WIDTH-1:0]  Gray encoding of i_bin
// ---------------------------------------------------------------------------
module bin2gray_comb #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    // The logical shift feeds a zero into the MSB position, so the MSB passes
    // through unchanged. With WIDTH = 1 the output equals the input.
    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/binary_to_gray_counter.sv
// ---------------------------------------------------------------------------
// binary_to_gray_counter
//
// Registered binary counter that publishes its value in both binary and Gray
// code. It is intended to drive a clock-crossing FIFO pointer that another
// domain resynchronizes. The Gray output comes straight from a flop, so it
// cannot glitch.
//
// Parameters:
//   WIDTH       : counter width; the count wraps modulo 2^WIDTH
//
// Ports:
//   clock       : input         rising-edge clock
//   aclr_n      : input         asynchronous active-low reset
//   sclr        : input         synchronous clear (highest priority)
//   load        : input         synchronous load of load_value
//   load_value  : input  [W-1]  binary value to load
//   inc         : input         increment by one
//   bin_out     : output [W-1]  registered binary count
//   gray_out    : output [W-1]  registered Gray encoding of bin_out
//   wrap        : output        one-cycle pulse after an all-ones -> 0 increment
// ---------------------------------------------------------------------------
module binary_to_gray_counter
    import gray_code_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    next_sel_e        w_sel;
    logic [WIDTH-1:0] w_nextBin;
    logic [WIDTH-1:0] w_nextGray;
    logic             w_nextWrap;
    logic             w_allOnes;

    assign w_allOnes = &r_bin;

    // Resolve the control inputs into one source, in the order
    // clear > load > increment > hold.
    always_comb begin
        w_sel = SEL_HOLD;
        if (sclr) begin
            w_sel = SEL_CLEAR;
        end else if (load) begin
            w_sel = SEL_LOAD;
        end else if (inc) begin
            w_sel = SEL_INC;
        end
    end

    // Compute the next binary value. A wrap is flagged only when an increment
    // rolls over from all-ones. A clear or load that lands on zero does not
    // count as a wrap.
    always_comb begin
        w_nextBin  = r_bin;
        w_nextWrap = 1'b0;
        case (w_sel)
            SEL_CLEAR: w_nextBin = '0;
            SEL_LOAD:  w_nextBin = load_value;
            SEL_INC: begin
                w_nextBin  = r_bin + WIDTH'(1);
                w_nextWrap = w_allOnes;
            end
            default:   w_nextBin = r_bin;
        endcase
    end

    // Encode the next binary value before the register rather than after it.
    // This keeps gray_out flop-driven and aligned with bin_out in the same
    // cycle.
    bin2gray_comb #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .i_bin  (w_nextBin),
        .o_gray (w_nextGray)
    );

    // Binary, Gray and wrap state all update together. Asserting reset forces
    // them to zero immediately, without waiting for a clock edge.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_nextBin;
            r_gray <= w_nextGray;
            r_wrap <= w_nextWrap;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// ---------------------------------------------------------------------------
// tb_binary_to_gray_counter
//
// Scoreboard bench for binary_to_gray_counter at WIDTH = 5. The stimulus
// side drives one control word per cycle and pushes the predicted outputs.
// An independent monitor pops one prediction after each rising edge and
// compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_binary_to_gray_counter;
    import gray_code_pkg::*;

    localparam int W      = 5;
    localparam int NCODES = 1 << W;

    logic         clock;
    logic         aclr_n;
    logic         sclr;
    logic         load;
    logic [W-1:0] load_value;
    logic         inc;
    logic [W-1:0] bin_out;
    logic [W-1:0] gray_out;
    logic         wrap;

    typedef struct {
        int binVal;
        int grayVal;
        int wrapVal;
        bit isInc;
    } exp_t;

    exp_t expQ[$];
    int   assertCount;
    int   failCount;
    int   wrapSeen;
    int   modelBin;
    int   reflGray[NCODES];

    binary_to_gray_counter #(
        .WIDTH (W)
    ) dut (
        .clock      (clock),
        .aclr_n     (aclr_n),
        .sclr       (sclr),
        .load       (load),
        .load_value (load_value),
        .inc        (inc),
        .bin_out    (bin_out),
        .gray_out   (gray_out),
        .wrap       (wrap)
    );

    // 10-time-unit clock period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference sequence built with the reflect-and-prefix construction
    // of the Gray code.
    function automatic void buildGrayTable();
        reflGray[0] = 0;
        for (int k = 0; k < W; k++) begin
            int n;
            n = 1 << k;
            for (int j = 0; j < n; j++) begin
                reflGray[n + j] = reflGray[n - 1 - j] | n;
            end
        end
    endfunction

    // Drives one control word for one clock. The outputs it should produce
    // are predicted and queued for the monitor.
    task automatic applyStimulus(input bit s, input bit l, input int lv, input bit i);
        exp_t e;
        bit   incTaken;
        @(negedge clock);
        sclr       = s;
        load       = l;
        load_value = W'(lv);
        inc        = i;
        incTaken   = !s && !l && i;
        e.wrapVal  = (incTaken && modelBin == NCODES - 1) ? 1 : 0;
        if (s)             modelBin = 0;
        else if (l)        modelBin = lv % NCODES;
        else if (i)        modelBin = (modelBin + 1) % NCODES;
        e.binVal  = modelBin;
        e.grayVal = reflGray[modelBin];
        e.isInc   = incTaken;
        expQ.push_back(e);
        @(posedge clock);
        #2;
        sclr = 1'b0;
        load = 1'b0;
        inc  = 1'b0;
    endtask

    // Monitor: samples 1 time unit after every rising edge and checks any
    // pending prediction.
    initial begin
        logic [W-1:0] prevGray;
        exp_t         e;
        prevGray = '0;
        forever begin
            @(posedge clock);
            #1;
            if (wrap) wrapSeen++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("bin_out", int'(bin_out), e.binVal);
                checkOutput("gray_out", int'(gray_out), e.grayVal);
                checkOutput("wrap", int'(wrap), e.wrapVal);
                checkOutput("gray2bin", int'(W'(gray2bin(32'(gray_out)))), e.binVal);
                if (e.isInc) begin
                    checkOutput("grayOneBitStep", $countones(gray_out ^ prevGray), 1);
                end
            end
            prevGray = gray_out;
        end
    end

    initial begin
        int drain;
        assertCount = 0;
        failCount   = 0;
        wrapSeen    = 0;
        modelBin    = 0;
        buildGrayTable();

        // Hold reset with inc asserted; nothing may count.
        aclr_n     = 1'b0;
        sclr       = 1'b0;
        load       = 1'b0;
        load_value = '0;
        inc        = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        checkOutput("resetBin", int'(bin_out), 0);
        checkOutput("resetGray", int'(gray_out), 0);
        checkOutput("resetWrap", int'(wrap), 0);
        @(negedge clock);
        inc    = 1'b0;
        aclr_n = 1'b1;

        // Increment sweep from zero: 64 steps must produce two wraps.
        wrapSeen = 0;
        for (int i = 1; i <= 64; i++) begin
            applyStimulus(0, 0, 0, 1);
            if (i == 5)  checkOutput("spotGray5", int'(gray_out), 7);
            if (i == 10) checkOutput("spotGray10", int'(gray_out), 15);
            if (i == 31) checkOutput("spotGray31", int'(gray_out), 16);
        end
        checkOutput("sweepWrapCount", wrapSeen, 2);

        // Count to 13, then assert reset between clock edges.
        repeat (13) applyStimulus(0, 0, 0, 1);
        checkOutput("preResetBin", int'(bin_out), 13);
        #1;
        aclr_n = 1'b0;
        #1;
        checkOutput("asyncResetBin", int'(bin_out), 0);
        checkOutput("asyncResetGray", int'(gray_out), 0);
        checkOutput("asyncResetWrap", int'(wrap), 0);
        @(negedge clock);
        aclr_n   = 1'b1;
        modelBin = 0;

        // Directed wrap from 31, followed by one idle cycle.
        applyStimulus(0, 1, 31, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrapPulse", int'(wrap), 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrapOneCycle", int'(wrap), 0);

        // Load together with inc: the load wins and no increment is applied.
        applyStimulus(0, 1, 19, 1);
        checkOutput("loadBin", int'(bin_out), 19);
        checkOutput("loadGray", int'(gray_out), 26);

        // Clear beats load and inc, even at all-ones.
        applyStimulus(0, 1, 31, 0);
        applyStimulus(1, 1, 7, 1);
        checkOutput("prioBin", int'(bin_out), 0);
        checkOutput("prioWrap", int'(wrap), 0);

        // Hold at 22 for 10 cycles.
        applyStimulus(0, 1, 22, 0);
        repeat (10) applyStimulus(0, 0, 0, 0);
        checkOutput("holdGray", int'(gray_out), 29);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(15) == 0, $urandom_range(7) == 0,
                          int'($urandom_range(NCODES - 1)), $urandom_range(3) != 0);
        end

        // Bounded wait for the scoreboard to empty.
        drain = 0;
        while (expQ.size() > 0 && drain < 20) begin
            @(posedge clock);
            drain++;
        end
        #2;
        checkOutput("scoreboardDrained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
